// File: rtl/cmplx_pkg.sv
// Shared packed-complex definitions for the MOSSE correlation datapath.
// Words are packed {imag, real}, each half a signed two's-complement field.
package cmplx_pkg;

   localparam int CPLX_WIDTH = 32;
   localparam int CPLX_FRAC  = 16;
   localparam int RE_LSB     = 0;
   localparam int IM_LSB     = CPLX_WIDTH;

   typedef logic signed [CPLX_WIDTH-1:0]   cplx_comp_t;
   typedef logic        [2*CPLX_WIDTH-1:0] cplx_word_t;

   function automatic cplx_comp_t cplx_re(input cplx_word_t w);
      return w[RE_LSB +: CPLX_WIDTH];
   endfunction

   function automatic cplx_comp_t cplx_im(input cplx_word_t w);
      return w[IM_LSB +: CPLX_WIDTH];
   endfunction

   function automatic cplx_word_t cplx_pack(input cplx_comp_t re, input cplx_comp_t im);
      return {im, re};
   endfunction

endpackage

// File: rtl/cmplx_mult_stream_round_sat.sv
// Combinational round-half-up, arithmetic shift by FRAC and clamp to OUT_W bits.
// sat flags any beat whose shifted value fell outside the output range.
module round_sat #(
   parameter int IN_W  = 33,
   parameter int OUT_W = 16,
   parameter int FRAC  = 8
) (
   input  logic signed [IN_W-1:0]  in_v,
   output logic signed [OUT_W-1:0] out_v,
   output logic                    sat
);

   // One extra bit of headroom so adding the rounding constant can never wrap.
   localparam logic [IN_W:0] RND =
      (FRAC > 0) ? ((IN_W+1)'(1) << ((FRAC > 0) ? (FRAC - 1) : 0)) : '0;
   localparam logic signed [IN_W:0] MAX_V =
      {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [IN_W:0] MIN_V =
      {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

   logic signed [IN_W:0] biased;
   logic signed [IN_W:0] shifted;

   always_comb begin
      biased  = $signed({in_v[IN_W-1], in_v}) + $signed(RND);
      shifted = biased >>> FRAC;
      sat     = 1'b0;
      out_v   = shifted[OUT_W-1:0];
      if (shifted > MAX_V) begin
         out_v = MAX_V[OUT_W-1:0];
         sat   = 1'b1;
      end else if (shifted < MIN_V) begin
         out_v = MIN_V[OUT_W-1:0];
         sat   = 1'b1;
      end
   end

endmodule

// File: rtl/cmplx_mult_stream.sv
// Streaming element-wise complex multiplier P = A x B, three register stages,
// one beat per cycle, single pipeline enable driven by the output handshake.
module cmplx_mult_stream
   import cmplx_pkg::*;
#(
   parameter int WIDTH = CPLX_WIDTH,
   parameter int FRAC  = CPLX_FRAC
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [2*WIDTH-1:0]   s_a_tdata,
   input  logic [2*WIDTH-1:0]   s_b_tdata,
   input  logic                 s_tvalid,
   output logic                 s_tready,
   input  logic                 s_tlast,
   output logic [2*WIDTH-1:0]   m_tdata,
   output logic                 m_tvalid,
   input  logic                 m_tready,
   output logic                 m_tlast,
   output logic                 ovf
);

   localparam int PW = 2 * WIDTH;
   localparam int SW = 2 * WIDTH + 1;

   logic en;

   logic signed [WIDTH-1:0] a_re, a_im, b_re, b_im;

   logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
   logic signed [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
   logic signed [SW-1:0] sum_q [2];
   logic signed [SW-1:0] sum_d [2];
   logic signed [WIDTH-1:0] res [2];
   logic                    sat [2];

   logic v1_q, v1_d, v2_q, v2_d;
   logic l1_q, l1_d, l2_q, l2_d;
   logic [PW-1:0] m_tdata_q, m_tdata_d;
   logic          m_tvalid_q, m_tvalid_d;
   logic          m_tlast_q, m_tlast_d;
   logic          ovf_q, ovf_d;

   // Whole pipe moves together: a full output slot that is not being taken freezes everything.
   assign en       = ~m_tvalid_q | m_tready;
   assign s_tready = en;

   assign a_re = s_a_tdata[RE_LSB +: WIDTH];
   assign a_im = s_a_tdata[WIDTH +: WIDTH];
   assign b_re = s_b_tdata[RE_LSB +: WIDTH];
   assign b_im = s_b_tdata[WIDTH +: WIDTH];

   // Products go straight into the S1 registers so they pack into the DSP M-register.
   always_comb begin
      p_rr_d = p_rr_q;
      p_ii_d = p_ii_q;
      p_ri_d = p_ri_q;
      p_ir_d = p_ir_q;
      sum_d  = sum_q;
      if (en) begin
         p_rr_d   = PW'(a_re) * PW'(b_re);
         p_ii_d   = PW'(a_im) * PW'(b_im);
         p_ri_d   = PW'(a_re) * PW'(b_im);
         p_ir_d   = PW'(a_im) * PW'(b_re);
         sum_d[0] = SW'(p_rr_q) - SW'(p_ii_q);
         sum_d[1] = SW'(p_ri_q) + SW'(p_ir_q);
      end
   end

   always_ff @(posedge aclk) begin
      p_rr_q <= p_rr_d;
      p_ii_q <= p_ii_d;
      p_ri_q <= p_ri_d;
      p_ir_q <= p_ir_d;
      sum_q  <= sum_d;
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rs
         round_sat #(
            .IN_W  (SW),
            .OUT_W (WIDTH),
            .FRAC  (FRAC)
         ) u_round_sat (
            .in_v  (sum_q[gi]),
            .out_v (res[gi]),
            .sat   (sat[gi])
         );
      end
   endgenerate

   // tlast is qualified by valid at entry so an idle output never shows tlast.
   always_comb begin
      v1_d       = v1_q;
      v2_d       = v2_q;
      l1_d       = l1_q;
      l2_d       = l2_q;
      m_tvalid_d = m_tvalid_q;
      m_tlast_d  = m_tlast_q;
      m_tdata_d  = m_tdata_q;
      ovf_d      = ovf_q;
      if (en) begin
         v1_d       = s_tvalid;
         l1_d       = s_tvalid & s_tlast;
         v2_d       = v1_q;
         l2_d       = l1_q;
         m_tvalid_d = v2_q;
         m_tlast_d  = l2_q;
         m_tdata_d  = {res[1], res[0]};
         ovf_d      = ovf_q | (v2_q & (sat[0] | sat[1]));
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         l1_q       <= 1'b0;
         l2_q       <= 1'b0;
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
         m_tdata_q  <= '0;
         ovf_q      <= 1'b0;
      end else begin
         v1_q       <= v1_d;
         v2_q       <= v2_d;
         l1_q       <= l1_d;
         l2_q       <= l2_d;
         m_tvalid_q <= m_tvalid_d;
         m_tlast_q  <= m_tlast_d;
         m_tdata_q  <= m_tdata_d;
         ovf_q      <= ovf_d;
      end
   end

   assign m_tdata  = m_tdata_q;
   assign m_tvalid = m_tvalid_q;
   assign m_tlast  = m_tlast_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_cmplx_mult_stream.sv
// Scoreboard bench for cmplx_mult_stream at WIDTH=16, FRAC=8 (Q8.8).
// Driver pushes expected products on accept; a negedge monitor pops and compares.
module tb_cmplx_mult_stream;

   localparam int W = 16;
   localparam int F = 8;

   logic            aclk;
   logic            aresetn;
   logic [2*W-1:0]  s_a_tdata;
   logic [2*W-1:0]  s_b_tdata;
   logic            s_tvalid;
   logic            s_tready;
   logic            s_tlast;
   logic [2*W-1:0]  m_tdata;
   logic            m_tvalid;
   logic            m_tready;
   logic            m_tlast;
   logic            ovf;

   cmplx_mult_stream #(.WIDTH(W), .FRAC(F)) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .s_a_tdata (s_a_tdata),
      .s_b_tdata (s_b_tdata),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .s_tlast   (s_tlast),
      .m_tdata   (m_tdata),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tlast   (m_tlast),
      .ovf       (ovf)
   );

   typedef struct {
      int   re;
      int   im;
      logic last;
      int   acc_cyc;
      bit   chk_lat;
   } exp_t;

   exp_t exp_q[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int rdy_mode = 0;
   int drops    = 0;
   int out_cnt  = 0;
   bit fr_track = 0;
   int fr_first = -1;
   int fr_last  = -1;
   int fr_cnt   = 0;

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         m_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
   end

   function automatic int model(input longint v);
      longint r;
      r = (v + 128) >>> 8;
      if (r > 32767)  return 32767;
      if (r < -32768) return -32768;
      return int'(r);
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic send(input int ar, input int ai, input int br, input int bi,
                       input logic last, input int exp_re, input int exp_im);
      int  n;
      bit  done;
      logic signed [W-1:0] t_ar, t_ai, t_br, t_bi;
      n    = 0;
      done = 0;
      t_ar = W'(ar);
      t_ai = W'(ai);
      t_br = W'(br);
      t_bi = W'(bi);
      s_a_tdata = {t_ai, t_ar};
      s_b_tdata = {t_bi, t_br};
      s_tlast   = last;
      s_tvalid  = 1'b1;
      while (!done) begin
         @(negedge aclk);
         if (s_tready) begin
            exp_q.push_back('{exp_re, exp_im, last, cyc + 1, rdy_mode == 0});
            $display("accept a=(%0d,%0d) b=(%0d,%0d) last=%0b exp=(%0d,%0d)",
                     ar, ai, br, bi, last, exp_re, exp_im);
            done = 1;
         end else begin
            drops++;
            n++;
            if (n > 200) begin
               checks++;
               failures++;
               $display("FAIL accept_timeout: s_tready low for %0d cycles, required 1", n);
               done = 1;
            end
         end
         @(posedge aclk);
         #1;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_m(input int ar, input int ai, input int br, input int bi, input logic last);
      longint re, im;
      re = longint'(ar) * br - longint'(ai) * bi;
      im = longint'(ar) * bi + longint'(ai) * br;
      send(ar, ai, br, bi, last, model(re), model(im));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge aclk);
         n++;
      end
      check("drain_pending", exp_q.size(), 0);
      @(posedge aclk);
      #1;
   endtask

   // Monitor: handshake scoreboard plus AXI-stream hold and idle-tlast rules.
   logic           prev_stall = 1'b0;
   logic [2*W-1:0] prev_data  = '0;
   logic           prev_last  = 1'b0;

   always @(negedge aclk) begin
      exp_t e;
      int   got_re, got_im;
      if (aresetn) begin
         if (prev_stall) begin
            checks++;
            if (!(m_tvalid && m_tdata == prev_data && m_tlast == prev_last)) begin
               failures++;
               $display("FAIL hold: got v=%0b d=%h l=%0b expected v=1 d=%h l=%0b",
                        m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
            end
         end
         if (!m_tvalid) begin
            checks++;
            if (m_tlast) begin
               failures++;
               $display("FAIL tlast_idle: got m_tlast=1 with m_tvalid=0, expected 0");
            end
         end
         if (m_tvalid && m_tready) begin
            got_re = int'($signed(m_tdata[W-1:0]));
            got_im = int'($signed(m_tdata[2*W-1:W]));
            out_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat: got (%0d,%0d) expected no output", got_re, got_im);
            end else begin
               e = exp_q.pop_front();
               checks++;
               $display("output (%0d,%0d) last=%0b cyc=%0d", got_re, got_im, m_tlast, cyc);
               if (got_re != e.re || got_im != e.im || m_tlast != e.last) begin
                  failures++;
                  $display("FAIL product: got (%0d,%0d) last=%0b expected (%0d,%0d) last=%0b",
                           got_re, got_im, m_tlast, e.re, e.im, e.last);
               end
               if (e.chk_lat) check("latency", cyc - e.acc_cyc + 1, 3);
               if (fr_track) begin
                  if (fr_first < 0) fr_first = cyc;
                  fr_last = cyc;
                  fr_cnt++;
               end
            end
         end
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      int snap;
      aresetn   = 1'b0;
      s_a_tdata = '0;
      s_b_tdata = '0;
      s_tvalid  = 1'b0;
      s_tlast   = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      check("reset_m_tvalid", int'(m_tvalid), 0);
      check("reset_m_tdata",  int'(m_tdata), 0);
      check("reset_m_tlast",  int'(m_tlast), 0);
      check("reset_ovf",      int'(ovf), 0);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;

      // (1+2j)(3+4j) = -5+10j
      send(256, 512, 768, 1024, 1'b0, -1280, 2560);
      drain();
      check("basic_ovf", int'(ovf), 0);

      // 1/256 * 0.5 rounds up to 1/256; -1/256 * 0.5 rounds half up to 0
      send(1, 0, 128, 0, 1'b0, 1, 0);
      send(-1, 0, 128, 0, 1'b0, 0, 0);
      drain();
      check("round_ovf", int'(ovf), 0);

      send(32767, 0, 32767, 0, 1'b0, 32767, 0);
      drain();
      check("sat_pos_ovf", int'(ovf), 1);
      send(-32768, 0, 32767, 0, 1'b0, -32768, 0);
      drain();
      check("sat_neg_ovf", int'(ovf), 1);

      rdy_mode = 1;
      for (int k = 0; k < 16; k++)
         send_m(k * 100 - 800, k * 37, k * 53 + 7, 200 - k * 11, k == 15);
      drain();
      rdy_mode = 0;
      repeat (2) @(posedge aclk);
      #1;
      check("bp_ovf_sticky", int'(ovf), 1);

      drops    = 0;
      fr_first = -1;
      fr_cnt   = 0;
      fr_track = 1;
      for (int k = 0; k < 64; k++)
         send_m(k * 64 - 2000, 1000 - k * 32, 300, 17 + k, k == 63);
      drain();
      fr_track = 0;
      check("fullrate_tready_drops", drops, 0);
      check("fullrate_outputs", fr_cnt, 64);
      check("fullrate_span", fr_last - fr_first, 63);

      check("ovf_before_reset", int'(ovf), 1);
      send(256, 0, 256, 0, 1'b0, 256, 0);
      send(512, 0, 256, 0, 1'b0, 512, 0);
      send(768, 0, 256, 0, 1'b1, 768, 0);
      aresetn = 1'b0;
      #1;
      check("midreset_m_tvalid", int'(m_tvalid), 0);
      check("midreset_ovf", int'(ovf), 0);
      check("midreset_m_tlast", int'(m_tlast), 0);
      exp_q.delete();
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      snap = out_cnt;
      send(-256, 256, 512, 0, 1'b1, -512, 512);
      drain();
      repeat (6) @(posedge aclk);
      #1;
      check("post_reset_outputs", out_cnt - snap, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cmplx_mult_stream.md
Name: cmplx_mult_stream

Overview:
- Pipelined, streaming element-wise complex multiplier for the MOSSE correlation datapath; computes P = A × B per spectral bin.
- Sits directly downstream of the conjugation stage: B is normally the conjugated filter spectrum, A the FFT of the current patch.
- Uses the same packed complex format as the conjugation stage, {imag, real}, each half a signed two's-complement field.
- Fixed-point result is rounded and saturated back to WIDTH per component; streams with valid/ready backpressure.

Parameters:
- WIDTH, 32, bits per real/imag component (signed), inputs and output.
- FRAC, 16, fractional bits of the Qm.FRAC format; product is shifted right by FRAC. Legal range 0..WIDTH-1.

Ports:
- aclk  in  1  clock, all logic rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- s_a_tdata  in  2*WIDTH  operand A, {imag[2W-1:W], real[W-1:0]}.
- s_b_tdata  in  2*WIDTH  operand B, same packing.
- s_tvalid  in  1  A and B valid (joint beat).
- s_tready  out  1  block accepts beat.
- s_tlast  in  1  end-of-frame marker, forwarded with its beat.
- m_tdata  out  2*WIDTH  product, {imag, real}.
- m_tvalid  out  1  product valid.
- m_tready  in  1  downstream accepts.
- m_tlast  out  1  tlast aligned to m_tdata.
- ovf  out  1  sticky: set when any component saturated since reset.

Behaviour:
- Reset (aresetn low, async): all stage valids 0, m_tvalid=0, m_tdata=0, m_tlast=0, ovf=0. Data regs may reset to 0. Release is synchronous to aclk.
- Beat transfer on an input or output port occurs when valid && ready at a rising edge.
- Pipeline: 3 register stages, latency exactly 3 cycles from input accept to m_tvalid with m_tready held high. Throughput 1 beat/cycle.
  - S1: register ar*br, ai*bi, ar*bi, ai*br. Each product is 2W-bit signed.
  - S2: re = ar*br - ai*bi and im = ar*bi + ai*br, each 2W+1-bit signed.
  - S3: round, shift, saturate into the output register.
- Round: add 2^(FRAC-1) when FRAC>0 (round-half-up toward +inf), then arithmetic shift right by FRAC.
- Saturate: clamp to [-2^(W-1), 2^(W-1)-1]. Any clamp in a beat sets ovf on the S3 edge. ovf clears only on reset.
- Backpressure:
  - Global enable en = ~m_tvalid | m_tready. All stages, including valid and tlast shift registers, advance only when en=1.
  - s_tready = en, combinational from m_tready and m_tvalid; no path from s_tvalid to s_tready.
  - Bubbles inside the pipe are not compressed while stalled.
  - m_tdata, m_tvalid and m_tlast hold stable while m_tvalid && !m_tready (AXI-stream rule).
- tlast travels in a 3-deep shift register alongside valid. It is don't-care on invalid beats, but must be 0 on the output whenever m_tvalid=0.
- Simultaneous accept and emit under en=1: both occur in the same cycle; no loss or duplication.
- Reset mid-stream: in-flight beats are discarded; the first beat after release is again 3 cycles latent.
- Multiplies must map to DSP48. The S1 registers are the DSP M-registers; no extra logic between the product and the S1 register.

Decomposition:
- Package cmplx_pkg:
  - WIDTH/FRAC defaults.
  - Field index constants RE_LSB=0 and IM_LSB=WIDTH.
  - Functions cplx_re(), cplx_im() and cplx_pack().
  - Shared with the conjugation stage and downstream accumulator.
- One sub-module, round_sat: combinational; generic in width IN_W, OUT_W and FRAC. Does the rounding, shift, clamp and sat flag. Instantiated twice in S3 (re, im).

Test Plan (WIDTH=16, FRAC=8, Q8.8, 1.0=256):
- Basic product: A=(re 256, im 512), B=(768, 1024), i.e. (1+2j)(3+4j) -> m_tdata re=-1280, im=2560 exactly 3 cycles after accept; ovf=0.
- Rounding: A=(1,0), B=(128,0) -> re=1, im=0. Then A=(-1,0), B=(128,0) -> re=0 (half rounds up).
- Saturation: A=(32767,0), B=(32767,0) -> re=32767, ovf=1. Then A=(-32768,0), B=(32767,0) -> re=-32768. ovf stays 1 until reset.
- Backpressure: stream 16 beats with m_tready pseudo-random 50% -> all 16 outputs in order with correct values. m_tdata and m_tlast stable while stalled; tlast on beat 16 only.
- Full-rate: m_tready=1, s_tvalid=1 for 64 beats -> s_tready never drops; outputs on 64 consecutive cycles starting cycle 3.
- Reset mid-stream: pull aresetn low with 3 beats in flight -> m_tvalid=0, ovf=0 immediately (async). After release, a new beat emerges after 3 cycles; no stale beats.
